// File: rtl/input_conditioner_pkg.sv
// Shared constants for the external-input conditioner: ex_data_o source modes and
// the debounce counter sizing helper.
package input_cond_pkg;

    localparam int EDGE_LEVEL = 0;
    localparam int EDGE_RISE  = 1;
    localparam int EDGE_FALL  = 2;
    localparam int EDGE_BOTH  = 3;

    // One spare bit above what StableSamples-1 needs, so the compare never sees a wrap.
    function automatic int cnt_width(input int stable_samples);
        return $clog2(stable_samples) + 1;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// Single-bit conditioner: synchroniser chain, sample-qualified debounce counter,
// debounced level and registered rise/fall pulses.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int   SyncStages    = 2,
    parameter int   StableSamples = 4,
    parameter logic ResetLevel    = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic level_next_o,
    output logic rise_next_o,
    output logic fall_next_o
);

    localparam int CntWidth = cnt_width(StableSamples);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(StableSamples - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  sync;
    logic [CntWidth-1:0]   cnt_q;
    logic [CntWidth-1:0]   cnt_d;
    logic                  level_d;
    logic                  rise_d;
    logic                  fall_d;

    assign sync = sync_q[SyncStages-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= {SyncStages{ResetLevel}};
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], raw_i};
        end
    end

    // Any sample that agrees with the current level restarts the run.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_o;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick_i) begin
            if (sync == level_o) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                level_d = sync;
                rise_d  = sync;
                fall_d  = ~sync;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            level_o <= ResetLevel;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_o <= level_d;
            rise_o  <= rise_d;
            fall_o  <= fall_d;
        end
    end

    assign level_next_o = level_d;
    assign rise_next_o  = rise_d;
    assign fall_next_o  = fall_d;

endmodule

// File: rtl/input_conditioner.sv
// External-input conditioner: shared sample prescaler, per-bit debounce and the
// registered ex_data_o selector feeding the I/O peripheral.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int SyncStages    = 2,
    parameter int TickDivider   = 1000,
    parameter int StableSamples = 4,
    parameter int EdgeMode      = 1,
    parameter logic [data_width-1:0] ResetLevel = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [data_width-1:0] raw_i,
    output logic [data_width-1:0] level_o,
    output logic [data_width-1:0] rise_o,
    output logic [data_width-1:0] fall_o,
    output logic [data_width-1:0] ex_data_o
);

    if (SyncStages < 2) begin : g_bad_sync
        $fatal(1, "input_conditioner: SyncStages must be >= 2");
    end
    if (TickDivider < 1) begin : g_bad_div
        $fatal(1, "input_conditioner: TickDivider must be >= 1");
    end
    if (StableSamples < 1) begin : g_bad_stable
        $fatal(1, "input_conditioner: StableSamples must be >= 1");
    end
    if (EdgeMode < EDGE_LEVEL || EdgeMode > EDGE_BOTH) begin : g_bad_mode
        $fatal(1, "input_conditioner: EdgeMode must be 0..3");
    end

    localparam int PreWidth = (TickDivider > 1) ? $clog2(TickDivider) : 1;
    localparam logic [PreWidth-1:0] PreLast = PreWidth'(TickDivider - 1);
    localparam logic [data_width-1:0] ExReset = (EdgeMode == EDGE_LEVEL) ? ResetLevel : '0;

    logic [PreWidth-1:0]   pre_q;
    logic                  tick;
    logic [data_width-1:0] level_next;
    logic [data_width-1:0] rise_next;
    logic [data_width-1:0] fall_next;
    logic [data_width-1:0] ex_d;

    // With TickDivider=1 the counter is pinned at zero and tick stays high.
    assign tick = (pre_q == PreLast);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    for (genvar b = 0; b < data_width; b++) begin : g_bit
        debounce_bit #(
            .SyncStages    (SyncStages),
            .StableSamples (StableSamples),
            .ResetLevel    (ResetLevel[b])
        ) u_debounce (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .raw_i        (raw_i[b]),
            .tick_i       (tick),
            .level_o      (level_o[b]),
            .rise_o       (rise_o[b]),
            .fall_o       (fall_o[b]),
            .level_next_o (level_next[b]),
            .rise_next_o  (rise_next[b]),
            .fall_next_o  (fall_next[b])
        );
    end

    // Selecting from next-state values keeps ex_data_o aligned with level/rise/fall.
    always_comb begin
        ex_d = '0;
        case (EdgeMode)
            EDGE_LEVEL: ex_d = level_next;
            EDGE_RISE:  ex_d = rise_next;
            EDGE_FALL:  ex_d = fall_next;
            default:    ex_d = rise_next | fall_next;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ex_data_o <= ExReset;
        end else begin
            ex_data_o <= ex_d;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: four edge-mode instances share one raw stream, plus a minimum-latency instance.
module tb_input_conditioner;

    typedef struct packed {
        int             cyc;
        logic [7:0]     level;
        logic [7:0]     rise;
        logic [7:0]     fall;
        logic [3:0][7:0] ex;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] raw = 8'h00;
    logic [7:0] raw_min = 8'h00;

    logic [7:0] lvl [4];
    logic [7:0] rise [4];
    logic [7:0] fall [4];
    logic [7:0] ex [4];
    logic [7:0] lvl_min, rise_min, fall_min, ex_min;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    ev_t sb[$];
    ev_t sb_min[$];

    logic       irq_arm = 1'b0;
    logic       irq_clear = 1'b0;
    logic       irq_pend = 1'b0;
    int         irq_rises = 0;
    logic [7:0] irq_mask = 8'h01;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        input_conditioner #(
            .data_width    (8),
            .SyncStages    (2),
            .TickDivider   (4),
            .StableSamples (3),
            .EdgeMode      (m),
            .ResetLevel    (8'h00)
        ) u_dut (
            .clk_i     (clk),
            .reset_i   (rst),
            .raw_i     (raw),
            .level_o   (lvl[m]),
            .rise_o    (rise[m]),
            .fall_o    (fall[m]),
            .ex_data_o (ex[m])
        );
    end

    input_conditioner #(
        .data_width    (8),
        .SyncStages    (2),
        .TickDivider   (1),
        .StableSamples (1),
        .EdgeMode      (3),
        .ResetLevel    (8'h00)
    ) u_dut_min (
        .clk_i     (clk),
        .reset_i   (rst),
        .raw_i     (raw_min),
        .level_o   (lvl_min),
        .rise_o    (rise_min),
        .fall_o    (fall_min),
        .ex_data_o (ex_min)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Peripheral-side IRQ model: sticky pending bit set by masked ex_data, cleared by a read.
    always @(posedge clk) begin
        if (irq_clear) begin
            irq_pend <= 1'b0;
        end else if (irq_arm && ((ex[1] & irq_mask) != 8'h00)) begin
            irq_pend <= 1'b1;
            if (!irq_pend) irq_rises <= irq_rises + 1;
        end
    end

    task automatic push(input int c, input logic [7:0] l, input logic [7:0] r, input logic [7:0] f,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        ev_t e;
        e.cyc = c; e.level = l; e.rise = r; e.fall = f;
        e.ex[0] = e0; e.ex[1] = e1; e.ex[2] = e2; e.ex[3] = e3;
        sb.push_back(e);
    endtask

    task automatic push_min(input int c, input logic [7:0] l, input logic [7:0] r, input logic [7:0] f,
                            input logic [7:0] e3);
        ev_t e;
        e.cyc = c; e.level = l; e.rise = r; e.fall = f;
        e.ex = '0; e.ex[3] = e3;
        sb_min.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] prev_lvl [4] = '{default: 8'h00};
    logic [7:0] prev_ex0 = 8'h00;
    logic [7:0] prev_lvl_min = 8'h00;
    logic       hit, hit_min, ok;
    ev_t        got;

    always @(negedge clk) begin
        hit = 1'b0;
        for (int m = 0; m < 4; m++) begin
            if (lvl[m] !== prev_lvl[m] || (rise[m] | fall[m]) !== 8'h00) hit = 1'b1;
            if (m > 0 && ex[m] !== 8'h00) hit = 1'b1;
        end
        if (ex[0] !== prev_ex0) hit = 1'b1;
        if (hit) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL event: unexpected at cyc %0d level=%h rise=%h fall=%h", cyc, lvl[1], rise[1], fall[1]);
            end else begin
                got = sb.pop_front();
                ok = (cyc == got.cyc);
                for (int m = 0; m < 4; m++) begin
                    if (lvl[m] !== got.level || rise[m] !== got.rise || fall[m] !== got.fall || ex[m] !== got.ex[m])
                        ok = 1'b0;
                end
                if (!ok) begin
                    failed++;
                    $display("FAIL event: got cyc=%0d lvl=%h/%h/%h/%h rise=%h fall=%h ex=%h/%h/%h/%h, expected cyc=%0d lvl=%h rise=%h fall=%h ex=%h/%h/%h/%h",
                             cyc, lvl[0], lvl[1], lvl[2], lvl[3], rise[1], fall[1], ex[0], ex[1], ex[2], ex[3],
                             got.cyc, got.level, got.rise, got.fall, got.ex[0], got.ex[1], got.ex[2], got.ex[3]);
                end
            end
        end
        for (int m = 0; m < 4; m++) prev_lvl[m] = lvl[m];
        prev_ex0 = ex[0];

        hit_min = (lvl_min !== prev_lvl_min) || ((rise_min | fall_min | ex_min) !== 8'h00);
        if (hit_min) begin
            tests++;
            if (sb_min.size() == 0) begin
                failed++;
                $display("FAIL min_event: unexpected at cyc %0d level=%h rise=%h fall=%h", cyc, lvl_min, rise_min, fall_min);
            end else begin
                got = sb_min.pop_front();
                if (cyc != got.cyc || lvl_min !== got.level || rise_min !== got.rise ||
                    fall_min !== got.fall || ex_min !== got.ex[3]) begin
                    failed++;
                    $display("FAIL min_event: got cyc=%0d lvl=%h rise=%h fall=%h ex=%h, expected cyc=%0d lvl=%h rise=%h fall=%h ex=%h",
                             cyc, lvl_min, rise_min, fall_min, ex_min, got.cyc, got.level, got.rise, got.fall, got.ex[3]);
                end
            end
        end
        prev_lvl_min = lvl_min;
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("reset_level_m%0d", m), {24'h0, lvl[m]}, 32'h0);
            check($sformatf("reset_ex_m%0d", m), {24'h0, ex[m]}, 32'h0);
        end
        check("reset_min_level", {24'h0, lvl_min}, 32'h0);
        rst = 1'b0;

        // Clean rise and fall on bit 0: ticks at posedges 4,8,..; first qualifying tick is 8.
        wait_to(2);   push(16, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01); raw = 8'h01;
        wait_to(18);  push(32, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01); raw = 8'h00;
        // Minimum latency instance: level moves 3 clocks after raw.
        wait_to(20);  push_min(23, 8'h81, 8'h81, 8'h00, 8'h81); raw_min = 8'h81;
        wait_to(30);  push_min(33, 8'h80, 8'h00, 8'h01, 8'h01); raw_min = 8'h80;
        // Bounce: two qualifying ticks (40,44), then tick 48 sees the old level again.
        wait_to(34);  raw = 8'h01;
        wait_to(44);  raw = 8'h00;
        wait_to(50);  push(64, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01); raw = 8'h01;
                      push_min(53, 8'h00, 8'h00, 8'h80, 8'h80); raw_min = 8'h00;
        wait_to(66);  push(80, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01); raw = 8'h00;
        // Multi-bit transitions.
        wait_to(82);  push(96, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'hA5); raw = 8'hA5;
        wait_to(98);  push(112, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'hA5); raw = 8'h00;
        wait_to(114); push(128, 8'h3C, 8'h3C, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h3C); raw = 8'h3C;
        // Bit 0 qualifies on ticks 136,140; reset lands before tick 144 would flip it.
        wait_to(130); raw = 8'h3D;
        wait_to(141);
        push(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        check("async_reset_level", {24'h0, lvl[1]}, 32'h0);
        check("async_reset_ex0", {24'h0, ex[0]}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Counting restarts from scratch: ticks 4,8,12.
        push(12, 8'h3D, 8'h3D, 8'h00, 8'h3D, 8'h3D, 8'h00, 8'h3D);
        wait_to(14);  push(28, 8'h3C, 8'h00, 8'h01, 8'h3C, 8'h00, 8'h01, 8'h01); raw = 8'h3C;
        // IRQ integration: hold bit 0 high for 50 ticks after its rise.
        wait_to(30);  irq_arm = 1'b1;
                      push(44, 8'h3D, 8'h01, 8'h00, 8'h3D, 8'h01, 8'h00, 8'h01); raw = 8'h3D;
        wait_to(244);
        check("irq_single_assert", irq_rises, 32'd1);
        check("irq_pending", {31'h0, irq_pend}, 32'h1);
        irq_clear = 1'b1;
        @(posedge clk); #1;
        irq_clear = 1'b0;
        wait_to(284);
        check("irq_stays_low", {31'h0, irq_pend}, 32'h0);
        check("irq_no_reassert", irq_rises, 32'd1);
        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("sb_min_drained", sb_min.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        failed++;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "watchdog");
    end

endmodule
